// File: rtl/divider_pkg.sv
// Shared definitions for the sequential divider: FSM state encoding and default width.
package divider_pkg;

   localparam int unsigned DEFAULT_WIDTH = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/sequential_divider_div_step.sv
// One restoring-division iteration: shift in a dividend bit, compare, conditionally subtract.
import divider_pkg::*;

module div_step #(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic [WIDTH-1:0] rem_in,
   input  logic             bit_in,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_out,
   output logic             q_bit
);

   logic [WIDTH:0] shifted;
   logic [WIDTH:0] diff;

   // The restored remainder is always < divisor, so WIDTH bits suffice between steps.
   always_comb begin
      shifted = {rem_in, bit_in};
      diff    = shifted - {1'b0, divisor};
      q_bit   = (shifted >= {1'b0, divisor});
      rem_out = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
   end

endmodule

// File: rtl/sequential_divider.sv
// Multi-cycle unsigned restoring divider (2*WIDTH-bit dividend / WIDTH-bit divisor).
// Optional divide-by-zero fast path and divByZero flag under macro DIV_BY_ZERO_DETECT_EN.
import divider_pkg::*;

module sequential_divider #(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [2*WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0]   divisor,
   output logic [2*WIDTH-1:0] quotient,
   output logic [WIDTH-1:0]   remainder,
   output logic               busy,
   output logic               quotientDone
`ifdef DIV_BY_ZERO_DETECT_EN
   ,
   output logic               divByZero
`endif
);

   localparam int unsigned CW = $clog2(2 * WIDTH);
   localparam logic [CW-1:0] LAST = CW'(2 * WIDTH - 1);

   state_t             state, next_state;
   logic [2*WIDTH-1:0] dvd_q;
   logic [WIDTH-1:0]   dvs_q;
   logic [WIDTH-1:0]   rem_q;
   logic [2*WIDTH-1:0] quo_q;
   logic [CW-1:0]      count;
   logic               accept;
   logic               last_step;
   logic               zero_skip;
   logic [WIDTH-1:0]   step_rem;
   logic               step_q;

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem_in  (rem_q),
      .bit_in  (dvd_q[2*WIDTH-1]),
      .divisor (dvs_q),
      .rem_out (step_rem),
      .q_bit   (step_q)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= next_state;
   end

   always_comb begin
      next_state = state;
      accept     = 1'b0;
      last_step  = 1'b0;
      zero_skip  = 1'b0;
      unique case (state)
         IDLE, DONE: begin
            if (start) begin
               accept     = 1'b1;
               next_state = RUN;
            end
         end
         RUN: begin
            last_step = (count == LAST);
`ifdef DIV_BY_ZERO_DETECT_EN
            zero_skip = (dvs_q == '0);
`endif
            if (last_step || zero_skip) next_state = DONE;
         end
         default: next_state = IDLE;
      endcase
      busy         = (state == RUN);
      quotientDone = (state == DONE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dvd_q <= '0;
         dvs_q <= '0;
         rem_q <= '0;
         quo_q <= '0;
         count <= '0;
`ifdef DIV_BY_ZERO_DETECT_EN
         divByZero <= 1'b0;
`endif
      end else if (accept) begin
         dvd_q <= dividend;
         dvs_q <= divisor;
         rem_q <= '0;
         quo_q <= '0;
         count <= '0;
`ifdef DIV_BY_ZERO_DETECT_EN
         divByZero <= 1'b0;
`endif
      end else if (state == RUN) begin
         // Zero divisor: same values the full iteration would produce, in one cycle.
         if (zero_skip) begin
            quo_q <= '1;
            rem_q <= dvd_q[WIDTH-1:0];
            count <= '0;
`ifdef DIV_BY_ZERO_DETECT_EN
            divByZero <= 1'b1;
`endif
         end else begin
            dvd_q <= dvd_q << 1;
            rem_q <= step_rem;
            quo_q <= {quo_q[2*WIDTH-2:0], step_q};
            count <= last_step ? '0 : count + 1'b1;
         end
      end
   end

   assign quotient  = quo_q;
   assign remainder = rem_q;

endmodule

// File: tb/tb_sequential_divider.sv
// Directed self-checking bench for sequential_divider at WIDTH=4 (honours DIV_BY_ZERO_DETECT_EN).
module tb_sequential_divider;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic [7:0] dividend = '0;
   logic [3:0] divisor = '0;
   logic [7:0] quotient;
   logic [3:0] remainder;
   logic       busy;
   logic       quotientDone;
`ifdef DIV_BY_ZERO_DETECT_EN
   logic       dbz;
`endif

   int total = 0;
   int bad   = 0;

   sequential_divider #(.WIDTH(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .dividend     (dividend),
      .divisor      (divisor),
      .quotient     (quotient),
      .remainder    (remainder),
      .busy         (busy),
      .quotientDone (quotientDone)
`ifdef DIV_BY_ZERO_DETECT_EN
      ,
      .divByZero    (dbz)
`endif
   );

   always #5 clk = ~clk;

   // Counts edges from the accepting edge until quotientDone, bounded at 50.
   task automatic wait_done(output int cyc);
      cyc = 0;
      while (!quotientDone && cyc < 50) begin
         @(posedge clk); #1;
         cyc++;
      end
   endtask

   task automatic run_op(input logic [7:0] a, input logic [3:0] b, output int cyc);
      @(posedge clk); #1;
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(cyc);
   endtask

   task automatic test_reset;
      rst   = 1'b0;
      start = 1'b1;
      dividend = 8'd200;
      divisor  = 4'd13;
      repeat (3) @(posedge clk);
      #1;
      total++; if (quotient !== 8'd0) begin bad++; $display("FAIL reset_quotient got=%0d want=0", quotient); end
      total++; if (remainder !== 4'd0) begin bad++; $display("FAIL reset_remainder got=%0d want=0", remainder); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
      total++; if (quotientDone !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", quotientDone); end
`ifdef DIV_BY_ZERO_DETECT_EN
      total++; if (dbz !== 1'b0) begin bad++; $display("FAIL reset_dbz got=%b want=0", dbz); end
`endif
      start = 1'b0;
      rst   = 1'b1;
   endtask

   task automatic test_basic;
      int cyc;
      run_op(8'd200, 4'd13, cyc);
      total++; if (cyc !== 8) begin bad++; $display("FAIL basic_latency got=%0d want=8", cyc); end
      total++; if (quotient !== 8'd15) begin bad++; $display("FAIL basic_quotient got=%0d want=15", quotient); end
      total++; if (remainder !== 4'd5) begin bad++; $display("FAIL basic_remainder got=%0d want=5", remainder); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_done got=%b want=0", busy); end
   endtask

   task automatic test_vectors;
      logic [7:0] va [5] = '{8'd255, 8'd7, 8'd66, 8'd0, 8'd254};
      logic [3:0] vb [5] = '{4'd1, 4'd9, 4'd6, 4'd5, 4'd15};
      logic [7:0] vq [5] = '{8'd255, 8'd0, 8'd11, 8'd0, 8'd16};
      logic [3:0] vr [5] = '{4'd0, 4'd7, 4'd0, 4'd0, 4'd14};
      int cyc;
      for (int i = 0; i < 5; i++) begin
         run_op(va[i], vb[i], cyc);
         total++; if (cyc !== 8) begin bad++; $display("FAIL vec%0d_latency got=%0d want=8", i, cyc); end
         total++; if (quotient !== vq[i]) begin bad++; $display("FAIL vec%0d_quotient got=%0d want=%0d", i, quotient, vq[i]); end
         total++; if (remainder !== vr[i]) begin bad++; $display("FAIL vec%0d_remainder got=%0d want=%0d", i, remainder, vr[i]); end
      end
   endtask

   task automatic test_div_zero;
      int cyc;
      run_op(8'hA5, 4'd0, cyc);
`ifdef DIV_BY_ZERO_DETECT_EN
      total++; if (cyc !== 1) begin bad++; $display("FAIL dz_latency got=%0d want=1", cyc); end
      total++; if (dbz !== 1'b1) begin bad++; $display("FAIL dz_flag got=%b want=1", dbz); end
`else
      total++; if (cyc !== 8) begin bad++; $display("FAIL dz_latency got=%0d want=8", cyc); end
`endif
      total++; if (quotient !== 8'hFF) begin bad++; $display("FAIL dz_quotient got=%0h want=ff", quotient); end
      total++; if (remainder !== 4'd5) begin bad++; $display("FAIL dz_remainder got=%0d want=5", remainder); end
`ifdef DIV_BY_ZERO_DETECT_EN
      run_op(8'd50, 4'd7, cyc);
      total++; if (dbz !== 1'b0) begin bad++; $display("FAIL dz_clear got=%b want=0", dbz); end
      total++; if (quotient !== 8'd7) begin bad++; $display("FAIL dz_after_quotient got=%0d want=7", quotient); end
`endif
   endtask

   task automatic test_reset_mid_run;
      int cyc;
      @(posedge clk); #1;
      dividend = 8'd200;
      divisor  = 4'd13;
      start    = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      rst = 1'b0;
      #1;
      total++; if (quotient !== 8'd0) begin bad++; $display("FAIL midrst_quotient got=%0d want=0", quotient); end
      total++; if (remainder !== 4'd0) begin bad++; $display("FAIL midrst_remainder got=%0d want=0", remainder); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b want=0", busy); end
      total++; if (quotientDone !== 1'b0) begin bad++; $display("FAIL midrst_done got=%b want=0", quotientDone); end
      start    = 1'b1;
      dividend = 8'd100;
      divisor  = 4'd7;
      @(posedge clk); #1;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_start_ignored got=%b want=0", busy); end
      rst = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL midrst_first_edge got=%b want=1", busy); end
      wait_done(cyc);
      total++; if (cyc !== 8) begin bad++; $display("FAIL midrst_latency got=%0d want=8", cyc); end
      total++; if (quotient !== 8'd14) begin bad++; $display("FAIL midrst_quotient2 got=%0d want=14", quotient); end
      total++; if (remainder !== 4'd2) begin bad++; $display("FAIL midrst_remainder2 got=%0d want=2", remainder); end
   endtask

   task automatic test_ignore_during_run;
      int cyc;
      @(posedge clk); #1;
      dividend = 8'd200;
      divisor  = 4'd13;
      start    = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      start    = 1'b1;
      dividend = 8'd50;
      divisor  = 4'd3;
      repeat (2) begin @(posedge clk); #1; end
      start    = 1'b0;
      dividend = 8'd0;
      divisor  = 4'd0;
      cyc = 3;
      while (!quotientDone && cyc < 50) begin @(posedge clk); #1; cyc++; end
      total++; if (cyc !== 8) begin bad++; $display("FAIL ignore_latency got=%0d want=8", cyc); end
      total++; if (quotient !== 8'd15) begin bad++; $display("FAIL ignore_quotient got=%0d want=15", quotient); end
      total++; if (remainder !== 4'd5) begin bad++; $display("FAIL ignore_remainder got=%0d want=5", remainder); end
   endtask

   task automatic test_back_to_back;
      int cyc;
      @(posedge clk); #1;
      dividend = 8'd99;
      divisor  = 4'd10;
      start    = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      total++; if (quotientDone !== 1'b0) begin bad++; $display("FAIL b2b_done_fall got=%b want=0", quotientDone); end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_busy got=%b want=1", busy); end
      wait_done(cyc);
      total++; if (cyc !== 8) begin bad++; $display("FAIL b2b_latency got=%0d want=8", cyc); end
      total++; if (quotient !== 8'd9) begin bad++; $display("FAIL b2b_quotient got=%0d want=9", quotient); end
      total++; if (remainder !== 4'd9) begin bad++; $display("FAIL b2b_remainder got=%0d want=9", remainder); end
   endtask

   task automatic test_hold_start;
      int cyc;
      @(posedge clk); #1;
      dividend = 8'd35;
      divisor  = 4'd4;
      start    = 1'b1;
      @(posedge clk); #1;
      wait_done(cyc);
      total++; if (cyc !== 8) begin bad++; $display("FAIL hold_latency got=%0d want=8", cyc); end
      total++; if (quotient !== 8'd8) begin bad++; $display("FAIL hold_quotient got=%0d want=8", quotient); end
      total++; if (remainder !== 4'd3) begin bad++; $display("FAIL hold_remainder got=%0d want=3", remainder); end
      @(posedge clk); #1;
      start = 1'b0;
      total++; if (quotientDone !== 1'b0) begin bad++; $display("FAIL hold_restart_done got=%b want=0", quotientDone); end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL hold_restart_busy got=%b want=1", busy); end
      wait_done(cyc);
      total++; if (cyc !== 8) begin bad++; $display("FAIL hold_latency2 got=%0d want=8", cyc); end
      repeat (3) begin @(posedge clk); #1; end
      total++; if (quotientDone !== 1'b1) begin bad++; $display("FAIL hold_done_stable got=%b want=1", quotientDone); end
      total++; if (quotient !== 8'd8) begin bad++; $display("FAIL hold_quotient_stable got=%0d want=8", quotient); end
      total++; if (remainder !== 4'd3) begin bad++; $display("FAIL hold_remainder_stable got=%0d want=3", remainder); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_vectors();
      test_div_zero();
      test_reset_mid_run();
      test_ignore_during_run();
      test_back_to_back();
      test_hold_start();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
